frb_threshold_trigger: RTL and testbench
========================================

# frb_threshold_trigger

Detection stage that sits directly downstream of the 128-sample moving average in the one-channel FRB chain. It compares each smoothed power sample against a runtime threshold, tracks each above-threshold excursion, and reports one event per excursion: peak value, sample timestamp of the peak, and duration. After each report a configurable holdoff suppresses retriggering on the same burst. Events shorter than a minimum length are rejected.

## Interface
- DIN_WIDTH, 25, width of din/threshold/peak (signed)
- DIN_POINT, 24, binary point of din; informational only, arithmetic is raw two's complement
- TS_WIDTH, 32, width of sample timestamp counter
- LEN_WIDTH, 16, width of event_len, min_len, holdoff
- Clocking and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-low reset
- din  in  DIN_WIDTH  signed smoothed power from moving average
- din_valid  in  1  din qualifier
- threshold  in  DIN_WIDTH  signed trigger level
- min_len  in  LEN_WIDTH  minimum excursion length (valid samples) to report
- holdoff  in  LEN_WIDTH  valid samples ignored after a report
- arm  in  1  detection enable
- trig_valid  out  1  one-cycle pulse: event report valid
- peak  out  DIN_WIDTH  max din within event
- peak_ts  out  TS_WIDTH  sample index of peak
- event_len  out  LEN_WIDTH  excursion length in valid samples, saturating
- busy  out  1  high in ABOVE or HOLDOFF

## Operation
- ts counter: increments on every din_valid regardless of state/arm; index of a sample = counter value before increment; wraps modulo 2^TS_WIDTH.
- Above test: signed din > threshold (strict). Only cycles with din_valid=1 are evaluated; din_valid=0 cycles change nothing except nothing.
- threshold, min_len, holdoff sampled live every valid sample; no latching.
- States:
  - IDLE: on valid sample, arm=1 and above -> ABOVE; load run_peak=din, run_ts=index, run_len=1.
  - ABOVE: valid and above -> run_len+1 (saturate at 2^LEN_WIDTH-1); if din > run_peak (strict, first occurrence wins ties) update run_peak/run_ts. Valid and not above -> terminate: if run_len >= min_len, report (peak/peak_ts/event_len <= run values, trig_valid pulse) then go HOLDOFF (or IDLE if holdoff==0); else discard, go IDLE, no pulse.
  - HOLDOFF: count valid samples; after holdoff of them, -> IDLE. Samples during holdoff never start events.
- arm=0: forces IDLE on the next clk edge from any state; in-progress event discarded, no report; holdoff aborted.
- Terminating sample is never counted in event_len and is never a start; the following valid sample is the first one evaluated from IDLE/HOLDOFF.
- min_len=0 or 1: every excursion reports.

## Timing
- Reset values: trig_valid=0, peak=0, peak_ts=0, event_len=0, busy=0, state IDLE, ts counter 0.
- trig_valid asserted on the clk edge that samples the terminating valid sample; high exactly one cycle.
- peak, peak_ts, event_len update in same cycle as trig_valid and hold until next report.
- busy rises on edge sampling the starting sample; falls on edge sampling the last holdoff sample (or terminating sample when holdoff==0 or discarded).
- Back-to-back din_valid every cycle fully supported; no backpressure.
- rst low mid-event: all state cleared asynchronously; no report emitted.

## Test plan
- threshold=100, min_len=1, holdoff=0, arm=1; din valid stream 0,0,150,300,200,50 (indices 0-5) -> one pulse at index-5 edge: peak=300, peak_ts=3, event_len=3.
- Same, din 150,300,300,50 -> peak=300, peak_ts at first 300 (tie keeps first).
- min_len=4; excursion of 3 samples above -> no trig_valid; excursion of 4 -> report event_len=4.
- holdoff=3; burst ends at index 10, then 200,200,200 at 11-13, 200,50 at 14-15 -> first report; second event starts at 14, reports event_len=1 at 15.
- arm dropped mid-excursion then restored with din above -> no report for aborted event; new event starts only after arm=1 at a valid above sample.
- rst asserted during ABOVE with din_valid gaps interleaved -> outputs at reset values, ts counter restarts at 0, first event afterward reports correct indices.

Source files
------------

// File: rtl/frb_threshold_trigger_if.sv
// Bundles the sample stream, runtime controls and event report of the FRB
// threshold trigger. The master drives samples and controls; the slave reports events.
interface frb_threshold_trigger_if #(
  parameter int DIN_WIDTH = 25,
  parameter int TS_WIDTH  = 32,
  parameter int LEN_WIDTH = 16
);
  logic signed [DIN_WIDTH-1:0] din;
  logic                        din_valid;
  logic signed [DIN_WIDTH-1:0] threshold;
  logic        [LEN_WIDTH-1:0] min_len;
  logic        [LEN_WIDTH-1:0] holdoff;
  logic                        arm;
  logic                        trig_valid;
  logic signed [DIN_WIDTH-1:0] peak;
  logic        [TS_WIDTH-1:0]  peak_ts;
  logic        [LEN_WIDTH-1:0] event_len;
  logic                        busy;

  modport master (
    output din, din_valid, threshold, min_len, holdoff, arm,
    input  trig_valid, peak, peak_ts, event_len, busy
  );

  modport slave (
    input  din, din_valid, threshold, min_len, holdoff, arm,
    output trig_valid, peak, peak_ts, event_len, busy
  );
endinterface

// File: rtl/frb_threshold_trigger.sv
// Threshold detector for smoothed FRB power: tracks each above-threshold excursion,
// reports peak / peak timestamp / length, then holds off retriggering.
module frb_threshold_trigger #(
  parameter int DIN_WIDTH = 25,
  parameter int DIN_POINT = 24,
  parameter int TS_WIDTH  = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  frb_threshold_trigger_if.slave bus
);

  // The binary point only documents the din format; compares are raw two's complement.
  if (DIN_POINT >= DIN_WIDTH) begin : g_bad_point
    $error("DIN_POINT must be below DIN_WIDTH");
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ABOVE   = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_e;

  localparam logic [LEN_WIDTH-1:0] LEN_MAX = {LEN_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TS_WIDTH-1:0]  TS_ONE  = {{(TS_WIDTH-1){1'b0}}, 1'b1};

  state_e                      state_q, state_d;
  logic        [TS_WIDTH-1:0]  ts_q, ts_d;
  logic signed [DIN_WIDTH-1:0] run_peak_q, run_peak_d;
  logic        [TS_WIDTH-1:0]  run_ts_q, run_ts_d;
  logic        [LEN_WIDTH-1:0] run_len_q, run_len_d;
  logic        [LEN_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                        trig_q, trig_d;
  logic signed [DIN_WIDTH-1:0] peak_q, peak_d;
  logic        [TS_WIDTH-1:0]  peak_ts_q, peak_ts_d;
  logic        [LEN_WIDTH-1:0] len_q, len_d;
  logic                        busy_q, busy_d;
  logic                        above_s;
  logic        [LEN_WIDTH:0]   hold_next_s;

  assign above_s     = bus.din > bus.threshold;
  assign hold_next_s = {1'b0, hold_cnt_q} + {1'b0, LEN_ONE};

  // State, running-event and report registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ts_q       <= {TS_WIDTH{1'b0}};
      run_peak_q <= {DIN_WIDTH{1'b0}};
      run_ts_q   <= {TS_WIDTH{1'b0}};
      run_len_q  <= {LEN_WIDTH{1'b0}};
      hold_cnt_q <= {LEN_WIDTH{1'b0}};
      trig_q     <= 1'b0;
      peak_q     <= {DIN_WIDTH{1'b0}};
      peak_ts_q  <= {TS_WIDTH{1'b0}};
      len_q      <= {LEN_WIDTH{1'b0}};
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      run_peak_q <= run_peak_d;
      run_ts_q   <= run_ts_d;
      run_len_q  <= run_len_d;
      hold_cnt_q <= hold_cnt_d;
      trig_q     <= trig_d;
      peak_q     <= peak_d;
      peak_ts_q  <= peak_ts_d;
      len_q      <= len_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and report logic; only valid samples advance the excursion tracker.
  always_comb begin
    state_d    = state_q;
    run_peak_d = run_peak_q;
    run_ts_d   = run_ts_q;
    run_len_d  = run_len_q;
    hold_cnt_d = hold_cnt_q;
    trig_d     = 1'b0;
    peak_d     = peak_q;
    peak_ts_d  = peak_ts_q;
    len_d      = len_q;

    if (bus.din_valid) begin
      ts_d = ts_q + TS_ONE;
    end else begin
      ts_d = ts_q;
    end

    // Disarming wins over everything, including a terminating sample.
    if (!bus.arm) begin
      state_d = ST_IDLE;
    end else if (bus.din_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (above_s) begin
            state_d    = ST_ABOVE;
            run_peak_d = bus.din;
            run_ts_d   = ts_q;
            run_len_d  = LEN_ONE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ABOVE: begin
          if (above_s) begin
            if (run_len_q != LEN_MAX) begin
              run_len_d = run_len_q + LEN_ONE;
            end else begin
              run_len_d = run_len_q;
            end
            if (bus.din > run_peak_q) begin
              run_peak_d = bus.din;
              run_ts_d   = ts_q;
            end else begin
              run_peak_d = run_peak_q;
            end
          end else if (run_len_q >= bus.min_len) begin
            trig_d     = 1'b1;
            peak_d     = run_peak_q;
            peak_ts_d  = run_ts_q;
            len_d      = run_len_q;
            hold_cnt_d = {LEN_WIDTH{1'b0}};
            if (bus.holdoff == {LEN_WIDTH{1'b0}}) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_HOLDOFF;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          // >= so a live reduction of holdoff cannot strand the counter.
          if (hold_next_s >= {1'b0, bus.holdoff}) begin
            state_d = ST_IDLE;
          end else begin
            hold_cnt_d = hold_next_s[LEN_WIDTH-1:0];
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.trig_valid = trig_q;
  assign bus.peak       = peak_q;
  assign bus.peak_ts    = peak_ts_q;
  assign bus.event_len  = len_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_frb_threshold_trigger.sv
// Scenario bench for frb_threshold_trigger: expected events are queued as stimulus
// is driven and matched against every trig_valid pulse.
module tb_frb_threshold_trigger;

  typedef struct {
    logic signed [24:0] peak;
    logic [31:0]        ts;
    logic [15:0]        len;
  } ev_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  ev_t  exp_q[$];

  frb_threshold_trigger_if #(.DIN_WIDTH(25), .TS_WIDTH(32), .LEN_WIDTH(16)) bus ();

  frb_threshold_trigger #(
    .DIN_WIDTH(25), .DIN_POINT(24), .TS_WIDTH(32), .LEN_WIDTH(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every report must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && bus.trig_valid === 1'b1) begin
      ev_t e;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_report got peak=%0d ts=%0d len=%0d, required no report",
                 bus.peak, bus.peak_ts, bus.event_len);
      end else begin
        e = exp_q.pop_front();
        checks = checks + 2;
        if (bus.peak !== e.peak) begin
          failures = failures + 1;
          $display("FAIL peak got %0d required %0d", bus.peak, e.peak);
        end
        if (bus.peak_ts !== e.ts) begin
          failures = failures + 1;
          $display("FAIL peak_ts got %0d required %0d", bus.peak_ts, e.ts);
        end
        if (bus.event_len !== e.len) begin
          failures = failures + 1;
          $display("FAIL event_len got %0d required %0d", bus.event_len, e.len);
        end
      end
    end
  end

  task automatic expect_ev(input logic signed [24:0] p, input logic [31:0] t,
                           input logic [15:0] l);
    ev_t e;
    e.peak = p;
    e.ts   = t;
    e.len  = l;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic signed [24:0] d, input logic v);
    bus.din       = d;
    bus.din_valid = v;
    @(posedge clk);
    #1;
    bus.din_valid = 1'b0;
  endtask

  task automatic configure(input logic signed [24:0] thr, input logic [15:0] ml,
                           input logic [15:0] ho);
    bus.threshold = thr;
    bus.min_len   = ml;
    bus.holdoff   = ho;
    bus.arm       = 1'b1;
  endtask

  task automatic do_reset();
    rst           = 1'b0;
    bus.din       = 25'sd0;
    bus.din_valid = 1'b0;
    bus.arm       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_busy(input string name, input logic req);
    checks = checks + 1;
    if (bus.busy !== req) begin
      failures = failures + 1;
      $display("FAIL %s busy got %b required %b", name, bus.busy, req);
    end
  endtask

  task automatic end_test(input string name);
    repeat (2) @(posedge clk);
    #1;
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL %s missing_reports got %0d pending required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.din = 25'sd0; bus.din_valid = 1'b0; bus.arm = 1'b0;
    bus.threshold = 25'sd0; bus.min_len = 16'd0; bus.holdoff = 16'd0;
    #12;
    checks = checks + 4;
    if (bus.trig_valid !== 1'b0) begin failures++; $display("FAIL reset trig_valid got %b required 0", bus.trig_valid); end
    if (bus.peak !== 25'sd0) begin failures++; $display("FAIL reset peak got %0d required 0", bus.peak); end
    if (bus.peak_ts !== 32'd0) begin failures++; $display("FAIL reset peak_ts got %0d required 0", bus.peak_ts); end
    if (bus.event_len !== 16'd0) begin failures++; $display("FAIL reset event_len got %0d required 0", bus.event_len); end
    check_busy("reset", 1'b0);
  endtask

  task automatic test_basic();
    do_reset();
    configure(25'sd100, 16'd1, 16'd0);
    expect_ev(25'sd300, 32'd3, 16'd3);
    send(25'sd0, 1'b1); send(25'sd0, 1'b1);
    check_busy("basic_before", 1'b0);
    send(25'sd150, 1'b1);
    check_busy("basic_start", 1'b1);
    send(25'sd300, 1'b1); send(25'sd200, 1'b1); send(25'sd50, 1'b1);
    check_busy("basic_end", 1'b0);
    end_test("basic");
  endtask

  task automatic test_tie();
    do_reset();
    configure(25'sd100, 16'd1, 16'd0);
    expect_ev(25'sd300, 32'd1, 16'd3);
    send(25'sd150, 1'b1); send(25'sd300, 1'b1); send(25'sd300, 1'b1); send(25'sd50, 1'b1);
    end_test("tie");
  endtask

  task automatic test_min_len();
    do_reset();
    configure(25'sd100, 16'd4, 16'd0);
    send(25'sd0, 1'b1);
    send(25'sd150, 1'b1); send(25'sd150, 1'b1); send(25'sd150, 1'b1);
    send(25'sd0, 1'b1);
    check_busy("min_len_discard", 1'b0);
    expect_ev(25'sd180, 32'd6, 16'd4);
    send(25'sd120, 1'b1); send(25'sd180, 1'b1); send(25'sd130, 1'b1); send(25'sd110, 1'b1);
    send(25'sd0, 1'b1);
    end_test("min_len");
  endtask

  task automatic test_holdoff();
    do_reset();
    configure(25'sd100, 16'd1, 16'd3);
    for (int i = 0; i < 8; i++) send(25'sd0, 1'b1);
    expect_ev(25'sd250, 32'd9, 16'd2);
    send(25'sd150, 1'b1); send(25'sd250, 1'b1); send(25'sd50, 1'b1);
    check_busy("holdoff_enter", 1'b1);
    send(25'sd200, 1'b1); send(25'sd500, 1'b0); send(25'sd200, 1'b1);
    check_busy("holdoff_mid", 1'b1);
    send(25'sd200, 1'b1);
    check_busy("holdoff_exit", 1'b0);
    expect_ev(25'sd200, 32'd14, 16'd1);
    send(25'sd200, 1'b1);
    check_busy("holdoff_restart", 1'b1);
    send(25'sd50, 1'b1);
    end_test("holdoff");
  endtask

  task automatic test_signed();
    do_reset();
    configure(-25'sd10, 16'd0, 16'd0);
    expect_ev(-25'sd3, 32'd3, 16'd3);
    send(-25'sd20, 1'b1); send(-25'sd5, 1'b1); send(-25'sd8, 1'b1);
    send(-25'sd3, 1'b1); send(-25'sd10, 1'b1);
    end_test("signed");
  endtask

  task automatic test_arm();
    do_reset();
    configure(25'sd100, 16'd1, 16'd0);
    send(25'sd0, 1'b1); send(25'sd150, 1'b1); send(25'sd200, 1'b1);
    bus.arm = 1'b0;
    send(25'sd300, 1'b1);
    check_busy("arm_drop", 1'b0);
    send(25'sd50, 1'b1);
    bus.arm = 1'b1;
    send(25'sd500, 1'b0);
    check_busy("arm_gap", 1'b0);
    expect_ev(25'sd250, 32'd5, 16'd1);
    send(25'sd250, 1'b1); send(25'sd50, 1'b1);
    end_test("arm");
  endtask

  task automatic test_rst_mid();
    do_reset();
    configure(25'sd100, 16'd1, 16'd0);
    expect_ev(25'sd150, 32'd1, 16'd1);
    send(25'sd0, 1'b1); send(25'sd150, 1'b1); send(25'sd50, 1'b1);
    send(25'sd120, 1'b1); send(25'sd999, 1'b0); send(25'sd130, 1'b1); send(25'sd0, 1'b0);
    #3 rst = 1'b0;
    #1;
    checks = checks + 4;
    if (bus.trig_valid !== 1'b0) begin failures++; $display("FAIL rst_mid trig_valid got %b required 0", bus.trig_valid); end
    if (bus.peak !== 25'sd0) begin failures++; $display("FAIL rst_mid peak got %0d required 0", bus.peak); end
    if (bus.peak_ts !== 32'd0) begin failures++; $display("FAIL rst_mid peak_ts got %0d required 0", bus.peak_ts); end
    if (bus.event_len !== 16'd0) begin failures++; $display("FAIL rst_mid event_len got %0d required 0", bus.event_len); end
    check_busy("rst_mid", 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    expect_ev(25'sd170, 32'd1, 16'd2);
    send(25'sd0, 1'b1); send(25'sd170, 1'b1); send(25'sd160, 1'b1); send(25'sd50, 1'b1);
    end_test("rst_mid");
  endtask

  task automatic test_back_to_back();
    do_reset();
    configure(25'sd100, 16'd1, 16'd0);
    expect_ev(25'sd150, 32'd0, 16'd1);
    expect_ev(25'sd200, 32'd2, 16'd1);
    send(25'sd150, 1'b1); send(25'sd50, 1'b1); send(25'sd200, 1'b1); send(25'sd100, 1'b1);
    end_test("back_to_back");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_tie();
    test_min_len();
    test_holdoff();
    test_signed();
    test_arm();
    test_rst_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
